// File: rtl/exponent_adjust.sv
// exponent_adjust
//   Final exponent stage for the FP multiply/divide datapath. Takes the 10-bit
//   two's-complement intermediate exponent, applies the mantissa-normalization
//   correction (+1 multiply with product MSB set, -1 divide with quotient MSB
//   clear), classifies the result and emits the 8-bit IEEE-754 single exponent
//   through a 2-stage valid/ready pipeline. Saturating overflow/underflow event
//   counters are kept for debug.
//
// Ports
//   clk, arst            clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake (in_ready is combinational from out_ready)
//   e, sel, m_msb        intermediate exponent, 0=mul/1=div, normalization bit
//   out_valid/out_ready  output handshake
//   exp_out, ovf, unf    final exponent and overflow/underflow flags
//   cnt_clr              synchronous clear of both counters (wins over increment)
//   ovf_cnt, unf_cnt     saturating counts of transferred flagged beats
module exponent_adjust #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       e,
  input  logic             sel,
  input  logic             m_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       exp_out,
  output logic             ovf,
  output logic             unf,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] unf_cnt
);

  // Sign-extend to 11 bits before correcting so -129..384 never wraps.
  function automatic logic signed [10:0] adjust_exp(input logic [9:0] ev,
                                                    input logic       s,
                                                    input logic       m);
    logic signed [10:0] ex;
    ex = {ev[9], ev};
    if (!s && m)
      ex = ex + 11'sd1;
    else if (s && !m)
      ex = ex - 11'sd1;
    return ex;
  endfunction

  // Returns {ovf, unf, exponent}; underflow flushes to zero, no subnormals.
  function automatic logic [9:0] classify(input logic signed [10:0] a);
    logic [9:0] r;
    if (a >= 11'sd255)
      r = {2'b10, 8'hFF};
    else if (a <= 11'sd0)
      r = {2'b01, 8'h00};
    else
      r = {2'b00, a[7:0]};
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic                vld_p1, vld_p2;
  logic signed [10:0]  adj_p1;
  logic [7:0]          exp_p2;
  logic                ovf_p2, unf_p2;
  logic                s1_adv, s2_adv, out_xfer;

  assign s2_adv   = !vld_p2 || out_ready;
  assign s1_adv   = !vld_p1 || s2_adv;
  assign in_ready = s1_adv;
  assign out_xfer = vld_p2 && out_ready;

  // ---- stage 1: normalization correction ----
  always_ff @(posedge clk or posedge arst) begin
    if (arst)
      vld_p1 <= 1'b0;
    else if (s1_adv)
      vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (s1_adv && in_valid)
      adj_p1 <= adjust_exp(e, sel, m_msb);
  end

  // ---- stage 2: classification ----
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      vld_p2 <= 1'b0;
      exp_p2 <= 8'h00;
      ovf_p2 <= 1'b0;
      unf_p2 <= 1'b0;
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1)
        {ovf_p2, unf_p2, exp_p2} <= classify(adj_p1);
    end
  end

  // ---- debug counters on output transfers ----
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else if (cnt_clr) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else if (out_xfer) begin
      if (ovf_p2)
        ovf_cnt <= sat_inc(ovf_cnt);
      if (unf_p2)
        unf_cnt <= sat_inc(unf_cnt);
    end
  end

  assign out_valid = vld_p2;
  assign exp_out   = exp_p2;
  assign ovf       = ovf_p2;
  assign unf       = unf_p2;

endmodule

// File: tb/tb_exponent_adjust.sv
module tb_exponent_adjust;

  logic       clk;
  logic       arst;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] e;
  logic       sel;
  logic       m_msb;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] exp_out;
  logic       ovf;
  logic       unf;
  logic       cnt_clr;
  logic [7:0] ovf_cnt;
  logic [7:0] unf_cnt;

  int checks = 0;
  int errors = 0;
  logic [9:0] sbq[$];   // expected {ovf, unf, exp_out}
  int m_ovf, m_unf;

  exponent_adjust #(.CNT_W(8)) dut (
    .clk(clk), .arst(arst), .in_valid(in_valid), .in_ready(in_ready),
    .e(e), .sel(sel), .m_msb(m_msb), .out_valid(out_valid),
    .out_ready(out_ready), .exp_out(exp_out), .ovf(ovf), .unf(unf),
    .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference behaviour computed with plain integers.
  function automatic logic [9:0] model(input logic [9:0] ev, input logic s, input logic m);
    int a;
    logic [31:0] u;
    a = $signed(ev);
    if (!s && m) a = a + 1;
    if (s && !m) a = a - 1;
    if (a >= 255) return {2'b10, 8'hFF};
    if (a <= 0) return {2'b01, 8'h00};
    u = a;
    return {2'b00, u[7:0]};
  endfunction

  // Offer one beat until accepted; expected response pushed at acceptance.
  task automatic send(input logic [9:0] ev, input logic s, input logic m,
                      input logic [7:0] xe, input logic xo, input logic xu);
    bit done;
    done = 0;
    in_valid = 1'b1; e = ev; sel = s; m_msb = m;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back({xo, xu, xe});
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout got in_ready=0 expected acceptance e=%0h", ev);
    end
    in_valid = 1'b0;
  endtask

  // Monitor: pops expected beats on every output transfer, tracks counters.
  always @(negedge clk or posedge arst) begin
    logic [9:0] x;
    logic xo, xu;
    if (arst) begin
      sbq.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      chk("ovf_cnt", ovf_cnt, m_ovf);
      chk("unf_cnt", unf_cnt, m_unf);
      xo = 1'b0; xu = 1'b0;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat got %0h expected no beat", {ovf, unf, exp_out});
        end else begin
          x = sbq.pop_front();
          chk("beat", {ovf, unf, exp_out}, x);
          xo = x[9]; xu = x[8];
        end
      end
      if (cnt_clr) begin
        m_ovf = 0; m_unf = 0;
      end else begin
        if (xo && m_ovf != 255) m_ovf++;
        if (xu && m_unf != 255) m_unf++;
      end
    end
  end

  initial begin
    #100us;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vals[4];
    int idx;
    logic [9:0] re;
    vals = '{10, 20, 30, 40};
    in_valid = 0; e = 0; sel = 0; m_msb = 0; out_ready = 1; cnt_clr = 0;
    arst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_exp_out", exp_out, 0);
    chk("rst_flags", {ovf, unf}, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    chk("rst_unf_cnt", unf_cnt, 0);
    arst = 0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Multiply normal case with latency check
    send(10'd130, 0, 1, 8'd131, 0, 0);
    @(negedge clk); chk("lat_cycle1_valid", out_valid, 0);
    @(negedge clk); chk("lat_cycle2_valid", out_valid, 1);
    @(posedge clk); #1;
    send(10'd130, 0, 0, 8'd130, 0, 0);
    // Divide boundaries
    send(10'h3FF, 1, 1, 8'h00, 0, 1);
    send(10'd1,   1, 0, 8'h00, 0, 1);
    send(10'd2,   1, 0, 8'h01, 0, 0);
    // Overflow boundaries
    send(10'd253, 0, 1, 8'd254, 0, 0);
    send(10'd254, 0, 1, 8'hFF, 1, 0);
    send(10'd383, 0, 1, 8'hFF, 1, 0);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure
    out_ready = 0;
    idx = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid = 1; e = vals[idx]; sel = 0; m_msb = 0;
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back({2'b00, 8'(vals[idx])});
        idx++;
      end
      if (cyc >= 2) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_exp", {ovf, unf, exp_out}, {2'b00, 8'd10});
      end
      @(posedge clk); #1;
    end
    chk("stall_accepted", idx, 2);
    chk("stall_in_ready", in_ready, 0);
    out_ready = 1;
    #1;
    chk("release_in_ready", in_ready, 1);
    for (int t = 0; t < 20 && idx < 4; t++) begin
      in_valid = 1; e = vals[idx];
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back({2'b00, 8'(vals[idx])});
        idx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 0;
    chk("bp_all_sent", idx, 4);
    repeat (4) @(posedge clk);
    #1;

    // Reset mid-flight
    out_ready = 0;
    send(10'd100, 0, 0, 8'd100, 0, 0);
    send(10'd50,  0, 0, 8'd50,  0, 0);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_exp", exp_out, 100);
    chk("pre_rst_ovf_cnt", ovf_cnt, 2);
    chk("pre_rst_unf_cnt", unf_cnt, 2);
    arst = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_exp", exp_out, 0);
    chk("mid_rst_ovf_cnt", ovf_cnt, 0);
    chk("mid_rst_unf_cnt", unf_cnt, 0);
    #2;
    arst = 0;
    out_ready = 1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_beat", out_valid, 0);
    end
    @(posedge clk); #1;

    // Counter saturation
    repeat (260) send(10'd300, 0, 0, 8'hFF, 1, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("sat_ovf_cnt", ovf_cnt, 255);
    chk("sat_unf_cnt", unf_cnt, 0);
    send(10'd300, 0, 0, 8'hFF, 1, 0);
    @(posedge clk); #1;
    chk("clr_beat_present", out_valid, 1);
    cnt_clr = 1;
    @(posedge clk); #1;
    cnt_clr = 0;
    chk("clr_ovf_cnt", ovf_cnt, 0);
    repeat (2) @(posedge clk);
    #1;

    // Random regression
    for (int c = 0; c < 500; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      re        = 10'($urandom_range(0, 511) - 128);
      e         = re;
      sel       = 1'($urandom_range(0, 1));
      m_msb     = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && in_ready)
        sbq.push_back(model(e, sel, m_msb));
      @(posedge clk); #1;
    end
    in_valid = 0;
    out_ready = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("drain_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
